// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared definitions for the round-robin bus arbiter.
//   arb_state_t       : arbiter state encodings (IDLE / BUSY / TURN)
//   idw()             : index width helper, max(1, clog2(n))
//   DEFAULT_MAX_BURST : default burst-length cap
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    localparam int DEFAULT_MAX_BURST = 8;

    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rr_priority_picker: combinational round-robin selector.
// Rotates the request vector so that bit ptr sits at position 0, finds the
// first set bit, then maps that position back to an absolute index.
// Ports:
//   vec    in  N    candidate request vector
//   ptr    in  IDW  search start index (always < N)
//   onehot out N    one-hot winner (zero when vec is zero)
//   idx    out IDW  binary winner index (zero when vec is zero)
//   any    out 1    vec has at least one bit set
module rr_priority_picker #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   vec,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   onehot,
    output logic [IDW-1:0] idx,
    output logic           any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rotated;
    logic [IDW-1:0] first;
    logic           found;
    logic [IDW:0]   sum;

    // Doubling the vector makes the right shift behave as a rotate.
    assign dbl     = {vec, vec} >> ptr;
    assign rotated = dbl[N-1:0];

    always_comb begin
        found = 1'b0;
        first = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && rotated[i]) begin
                found = 1'b1;
                first = IDW'(i);
            end
        end
    end

    always_comb begin
        sum = {1'b0, ptr} + {1'b0, first};
        if (sum >= (IDW+1)'(N)) begin
            sum = sum - (IDW+1)'(N);
        end
        idx = found ? sum[IDW-1:0] : '0;
    end

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            onehot[i] = found && (idx == IDW'(i));
        end
    end

    assign any = found;

endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: parametrised round-robin arbiter for the shared
// RISC-V_PE/CGRA bus. Ownership is held while the owner keeps requesting,
// capped at MAX_BURST cycles when others wait; optional one-cycle
// turnaround gap between owners (TURNAROUND=1).
// Optional feature macro: BUS_ARB_URGENT_EN (adds the urgent input; urgent
// requesters win arbitration points, never preempt a current owner).
// Ports:
//   clk         in  1        system clock, rising edge
//   reset       in  1        asynchronous active-low reset
//   req         in  NUM_REQ  level-sensitive per-PE requests
//   urgent      in  NUM_REQ  (BUS_ARB_URGENT_EN only) urgent qualifiers
//   grant       out NUM_REQ  registered one-hot grant, zero when no owner
//   grant_valid out 1        |grant
//   grant_id    out IDW      owner index, holds last value when idle
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = DEFAULT_MAX_BURST,
    parameter int TURNAROUND = 0,
    parameter int IDW        = idw(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
`ifdef BUS_ARB_URGENT_EN
    input  logic [NUM_REQ-1:0] urgent,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDW-1:0]     grant_id
);

    localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BCW-1:0] CAP = BCW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

    arb_state_t         state, state_nxt;
    logic [IDW-1:0]     ptr, ptr_nxt;
    logic [BCW-1:0]     burst_cnt, burst_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [IDW-1:0]     id_nxt;

    logic [NUM_REQ-1:0] cand, pick_vec, pick_onehot;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic [IDW:0]       ptr_inc;
    logic               owner_req, others, at_cap, take;

    assign owner_req = |(req & grant);
    assign others    = |(req & ~grant);
    assign at_cap    = (MAX_BURST != 0) && (burst_cnt == CAP);

    // While BUSY the current owner is masked out: on an owner release it is
    // not requesting anyway, and on a forced release it must not win again.
    assign cand = (state == BUSY) ? (req & ~grant) : req;

`ifdef BUS_ARB_URGENT_EN
    assign pick_vec = (|(cand & urgent)) ? (cand & urgent) : cand;
`else
    assign pick_vec = cand;
`endif

    rr_priority_picker #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_picker (
        .vec    (pick_vec),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        ptr_inc = {1'b0, pick_idx} + 1'b1;
        if (ptr_inc == (IDW+1)'(NUM_REQ)) begin
            ptr_inc = '0;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        id_nxt    = grant_id;
        ptr_nxt   = ptr;
        burst_nxt = burst_cnt;
        take      = 1'b0;

        case (state)
            BUSY: begin
                // Owner drop wins over a simultaneous cap hit; both release.
                if (!owner_req || (at_cap && others)) begin
                    if (TURNAROUND != 0) begin
                        grant_nxt = '0;
                        state_nxt = TURN;
                    end else if (pick_any) begin
                        take = 1'b1;
                    end else begin
                        grant_nxt = '0;
                        state_nxt = IDLE;
                    end
                end else if (at_cap) begin
                    burst_nxt = '0;
                end else if (MAX_BURST != 0) begin
                    burst_nxt = burst_cnt + 1'b1;
                end
            end
            default: begin
                // IDLE and TURN arbitrate identically.
                if (pick_any) begin
                    take = 1'b1;
                end else begin
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end
            end
        endcase

        if (take) begin
            grant_nxt = pick_onehot;
            id_nxt    = pick_idx;
            ptr_nxt   = ptr_inc[IDW-1:0];
            burst_nxt = '0;
            state_nxt = BUSY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            burst_cnt   <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            burst_cnt   <= burst_nxt;
            grant       <= grant_nxt;
            grant_valid <= |grant_nxt;
            grant_id    <= id_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req0 = '0, req1 = '0;
    logic [3:0] grant0, grant1;
    logic       gv0, gv1;
    logic [1:0] gid0, gid1;
    logic [3:0] exp_g;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_arbiter_rr #(
        .NUM_REQ    (4),
        .MAX_BURST  (4),
        .TURNAROUND (0)
    ) dut0 (
        .clk         (clk),
        .reset       (reset),
        .req         (req0),
`ifdef BUS_ARB_URGENT_EN
        .urgent      ('0),
`endif
        .grant       (grant0),
        .grant_valid (gv0),
        .grant_id    (gid0)
    );

    bus_arbiter_rr #(
        .NUM_REQ    (4),
        .MAX_BURST  (4),
        .TURNAROUND (1)
    ) dut1 (
        .clk         (clk),
        .reset       (reset),
        .req         (req1),
`ifdef BUS_ARB_URGENT_EN
        .urgent      ('0),
`endif
        .grant       (grant1),
        .grant_valid (gv1),
        .grant_id    (gid1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_grant", 32'(grant0), 32'h0);
        chk("rst_valid", 32'(gv0), 32'h0);
        chk("rst_id", 32'(gid0), 32'h0);
        reset = 1'b1;

        // Single one-cycle request from PE0
        tick();
        req0 = 4'b0001;
        tick();
        chk("t1_grant", 32'(grant0), 32'h1);
        chk("t1_valid", 32'(gv0), 32'h1);
        chk("t1_id", 32'(gid0), 32'h0);
        req0 = 4'b0000;
        tick();
        chk("t1_release", 32'(grant0), 32'h0);
        chk("t1_rel_valid", 32'(gv0), 32'h0);
        chk("t1_id_hold", 32'(gid0), 32'h0);

        // ptr=1, req=1010 -> PE1, then back-to-back handover to PE3
        req0 = 4'b1010;
        tick();
        chk("t2_grant", 32'(grant0), 32'h2);
        chk("t2_id", 32'(gid0), 32'h1);
        req0 = 4'b1000;
        tick();
        chk("t2_handover", 32'(grant0), 32'h8);
        chk("t2_id3", 32'(gid0), 32'h3);
        req0 = 4'b0000;
        tick();
        chk("t2_idle", 32'(grant0), 32'h0);
        chk("t2_id_hold", 32'(gid0), 32'h3);

        // All requesting, cap 4: each owner holds 4 cycles, no gaps, ptr=0
        req0 = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_g = 4'b0001 << ((i / 4) % 4);
            chk($sformatf("t3_rot%0d", i), 32'(grant0), 32'(exp_g));
            chk($sformatf("t3_valid%0d", i), 32'(gv0), 32'h1);
        end
        req0 = 4'b0000;
        tick();
        chk("t3_idle", 32'(grant0), 32'h0);

        // Sole requester past the cap keeps the bus without gaps
        req0 = 4'b0001;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk($sformatf("t4_sole%0d", i), 32'(grant0), 32'h1);
        end
        req0 = 4'b0000;
        tick();
        chk("t4_idle", 32'(grant0), 32'h0);

        // TURNAROUND=1: owner 2 drops with req[3] pending -> one idle cycle
        req1 = 4'b1100;
        tick();
        chk("t5_grant2", 32'(grant1), 32'h4);
        chk("t5_id2", 32'(gid1), 32'h2);
        req1 = 4'b1000;
        tick();
        chk("t5_gap", 32'(grant1), 32'h0);
        chk("t5_gap_valid", 32'(gv1), 32'h0);
        tick();
        chk("t5_grant3", 32'(grant1), 32'h8);
        chk("t5_id3", 32'(gid1), 32'h3);
        chk("t5_valid3", 32'(gv1), 32'h1);
        req1 = 4'b0000;
        tick();
        chk("t5_turn_end", 32'(grant1), 32'h0);

        // Asynchronous reset mid-burst while PE2 owns dut0
        req0 = 4'b0100;
        tick();
        chk("t6_grant2", 32'(grant0), 32'h4);
        tick();
        chk("t6_hold", 32'(grant0), 32'h4);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_grant", 32'(grant0), 32'h0);
        chk("t6_async_valid", 32'(gv0), 32'h0);
        chk("t6_async_id", 32'(gid0), 32'h0);
        #2;
        reset = 1'b1;
        tick();
        chk("t6_regrant", 32'(grant0), 32'h4);
        chk("t6_regrant_id", 32'(gid0), 32'h2);
        req0 = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
